gate_truth_checker: RTL

//  Driving/checking end of the basic-gate interface: generates every input

---
 rtl/gate_truth_checker.sv | 105 ++++++++++
 1 files changed

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: self-test driver/checker for an N-input combinational gate.
// Sweeps every input vector, holds each one for SETTLE+1 cycles and samples the
// gate output on the last edge. Each sample is compared with a truth table. The
// result is the pass flag, the mismatch count and the first failing vector.
module gate_truth_checker #(
    parameter int unsigned          N_IN   = 2,
    parameter int unsigned          SETTLE = 1,
    parameter logic [(1<<N_IN)-1:0] TRUTH  = 4'b1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            dut_out,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic            first_fail_vld,
    output logic [N_IN-1:0] first_fail_vec
);

    localparam int unsigned     SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [N_IN-1:0] LAST_VEC    = '1;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        CHECK,
        DONE
    } state_t;

    state_t        state;
    logic [SW-1:0] settle_cnt;
    logic          truth_bit;
    logic          mismatch;

    // Expected output for the vector on stim; X/Z on dut_out counts as a mismatch.
    always_comb begin
        truth_bit = TRUTH[stim];
        mismatch  = (dut_out !== truth_bit);
    end

    // Sweep FSM. stim also serves as the vector index while busy.
    // With SETTLE=0 the HOLD state is skipped, and CHECK repeats once per vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            stim           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        stim           <= '0;
                        err_cnt        <= '0;
                        first_fail_vld <= 1'b0;
                        first_fail_vec <= '0;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                        settle_cnt     <= '0;
                        state          <= (SETTLE == 0) ? CHECK : HOLD;
                    end
                end
                HOLD: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + 1'b1;
                        if (!first_fail_vld) begin
                            first_fail_vld <= 1'b1;
                            first_fail_vec <= stim;
                        end
                    end
                    if (stim == LAST_VEC) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_cnt == '0) && !mismatch;
                        stim  <= '0;
                    end else begin
                        stim  <= stim + 1'b1;
                        state <= (SETTLE == 0) ? CHECK : HOLD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
